// File: rtl/greenhouse_pkg.sv
// Shared types for the greenhouse actuator scheduler: FSM state encoding,
// channel indices and act_code helpers.
package greenhouse_pkg;

  localparam int N_CH = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GUARD = 2'd2
  } gh_state_t;

  // Channel index doubles as priority rank: higher index wins.
  typedef enum logic [2:0] {
    CH_NUTRI = 3'd0,
    CH_WATER = 3'd1,
    CH_TEMP  = 3'd2,
    CH_SPRAY = 3'd3,
    CH_FLUSH = 3'd4,
    CH_GAS   = 3'd5
  } gh_ch_t;

  localparam logic [2:0] ACT_NONE = 3'd0;

  function automatic logic [2:0] act_code_of(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

  function automatic logic [N_CH-1:0] onehot_of(input logic [2:0] idx);
    return 6'd1 << idx;
  endfunction

endpackage

// File: rtl/gh_prio_enc.sv
// Fixed-priority encoder: highest set bit of the masked request vector wins.
module gh_prio_enc
  import greenhouse_pkg::*;
(
  input  logic [N_CH-1:0] req_masked,
  output logic            valid,
  output logic [2:0]      idx
);

  always_comb begin
    valid = |req_masked;
    idx   = 3'd0;
    for (int i = 0; i < N_CH; i++) begin
      if (req_masked[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/greenhouse_actuator_scheduler.sv
// One-at-a-time actuator grant with minimum dwell, all-off guard and gas pre-emption.
// Optional continuous-on watchdog with per-channel lockout: GH_MAX_ON_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant, arbitrate eligible requests every cycle
// RUN   | one actuator granted, dwell counting, watching for release
// GUARD | all actuators off for GUARD_CYC cycles, then re-arbitrate
module greenhouse_actuator_scheduler
  import greenhouse_pkg::*;
#(
  parameter int DWELL_CYC = 16,
  parameter int GUARD_CYC = 4
`ifdef GH_MAX_ON_TIMEOUT_EN
  ,
  parameter int MAX_ON_CYC = 1024
`endif
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] A,
  output logic [2:0]      act_code,
  output logic            busy,
  output logic            timeout_flag
);

  localparam int DW_W = $clog2(DWELL_CYC + 1);
  localparam int GD_W = $clog2(GUARD_CYC + 1);

  gh_state_t       state;
  logic [2:0]      cur;
  logic [DW_W-1:0] dwell_cnt;
  logic [GD_W-1:0] guard_cnt;
  logic [N_CH-1:0] lock;
  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] higher;
  logic            dwell_ok;
  logic            guard_done;
  logic            rel;
  logic            release_now;
  logic            win_valid;
  logic [2:0]      win_idx;

`ifdef GH_MAX_ON_TIMEOUT_EN
  localparam int ON_W = $clog2(MAX_ON_CYC + 1);
  logic [ON_W-1:0] on_cnt;
  logic            wd_hit;
  assign wd_hit = (on_cnt >= ON_W'(MAX_ON_CYC - 1));
`else
  assign lock         = '0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    elig       = req & (en ? 6'h3F : 6'h20) & ~lock;
    higher     = elig & ~((6'd1 << (cur + 3'd1)) - 6'd1);
    dwell_ok   = (dwell_cnt >= DW_W'(DWELL_CYC - 1));
    guard_done = (guard_cnt >= GD_W'(GUARD_CYC - 1));
    // Gas bypasses dwell; every other release reason waits for it.
    rel = (!req[cur] && dwell_ok)
       || ((|higher) && dwell_ok)
       || (elig[CH_GAS] && (cur != CH_GAS))
       || (!en && (cur != CH_GAS) && dwell_ok);
`ifdef GH_MAX_ON_TIMEOUT_EN
    release_now = rel || wd_hit;
`else
    release_now = rel;
`endif
  end

  gh_prio_enc u_prio_enc (
    .req_masked(elig),
    .valid     (win_valid),
    .idx       (win_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cur       <= 3'd0;
      A         <= '0;
      act_code  <= ACT_NONE;
      busy      <= 1'b0;
      dwell_cnt <= '0;
      guard_cnt <= '0;
`ifdef GH_MAX_ON_TIMEOUT_EN
      on_cnt       <= '0;
      lock         <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
`ifdef GH_MAX_ON_TIMEOUT_EN
      // A locked channel stays locked until its request is seen low.
      lock <= (lock & req) | ((state == ST_RUN && wd_hit) ? onehot_of(cur) : 6'd0);
      if (state == ST_RUN && wd_hit) timeout_flag <= 1'b1;
`endif
      case (state)
        ST_RUN: begin
          if (release_now) begin
            state     <= ST_GUARD;
            A         <= '0;
            act_code  <= ACT_NONE;
            guard_cnt <= '0;
          end else begin
            if (dwell_cnt != DW_W'(DWELL_CYC)) dwell_cnt <= dwell_cnt + DW_W'(1);
`ifdef GH_MAX_ON_TIMEOUT_EN
            if (on_cnt != ON_W'(MAX_ON_CYC)) on_cnt <= on_cnt + ON_W'(1);
`endif
          end
        end
        default: begin
          if (state == ST_GUARD && !guard_done) begin
            if (guard_cnt != GD_W'(GUARD_CYC)) guard_cnt <= guard_cnt + GD_W'(1);
          end else if (win_valid) begin
            state     <= ST_RUN;
            cur       <= win_idx;
            A         <= onehot_of(win_idx);
            act_code  <= act_code_of(win_idx);
            busy      <= 1'b1;
            dwell_cnt <= '0;
`ifdef GH_MAX_ON_TIMEOUT_EN
            on_cnt <= '0;
`endif
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
